// File: rtl/tb_unpack_pkg.sv
// Shared types and constants for the trace-buffer readback unpacker.
package tb_unpack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } unpack_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_word_packer.sv
// Packs a stream of UART bytes little-endian into one DATA_WIDTH word.
module uart_word_packer
  import tb_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = BYTES_PER_WORD * 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  new_rx_data_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_done_o
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0]         byteIdx_q, byteIdx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  take;
  logic                  lastByte;

  assign take     = enable_i && new_rx_data_i && !clear_i;
  assign lastByte = (byteIdx_q == IW'(BPW - 1));

  // word_o is the merged word including the byte being sampled, so the
  // completed word is available in the same cycle as its last byte.
  always_comb begin
    word_d    = word_q;
    byteIdx_d = byteIdx_q;
    if (clear_i) begin
      byteIdx_d = '0;
    end else if (take) begin
      word_d[int'(byteIdx_q) * 8 +: 8] = rx_data_i;
      byteIdx_d = lastByte ? '0 : byteIdx_q + 1'b1;
    end
  end

  assign word_o      = word_d;
  assign word_done_o = take && lastByte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byteIdx_q <= '0;
      word_q    <= '0;
    end else begin
      byteIdx_q <= byteIdx_d;
      word_q    <= word_d;
    end
  end

endmodule

// File: rtl/tb_readback_unpacker.sv
// Assembles N-lane trace-buffer rows from UART bytes and hands them to a
// consumer through a single-entry output register with ready/valid flow.
module tb_readback_unpacker
  import tb_unpack_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = BYTES_PER_WORD * 8,
  parameter int TB_SIZE    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rx_data,
  input  logic                         new_rx_data,
  input  logic                         start,
  input  logic                         out_ready,
  output logic [N*DATA_WIDTH-1:0]      vector_out,
  output logic                         valid_out,
  output logic [$clog2(TB_SIZE+1)-1:0] row_count,
  output logic                         done,
  output logic                         overrun
);

  localparam int CW   = $clog2(TB_SIZE + 1);
  localparam int LW   = (N > 1) ? $clog2(N) : 1;
  localparam int ROWW = N * DATA_WIDTH;

  unpack_state_t         state_q, state_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [ROWW-1:0]       asm_q, asm_d;
  logic [ROWW-1:0]       vec_q, vec_d;
  logic                  valid_q, valid_d;
  logic [CW-1:0]         rowCount_q, rowCount_d;
  logic                  overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0] word;
  logic                  wordDone;
  logic                  rowDone;
  logic                  accept;
  logic [ROWW-1:0]       rowData;

  uart_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (start),
    .enable_i      (state_q == ACTIVE),
    .rx_data_i     (rx_data),
    .new_rx_data_i (new_rx_data),
    .word_o        (word),
    .word_done_o   (wordDone)
  );

  assign rowDone = wordDone && (lane_q == LW'(N - 1));
  assign accept  = valid_q && out_ready;

  always_comb begin
    rowData = asm_q;
    rowData[(N-1) * DATA_WIDTH +: DATA_WIDTH] = word;
  end

  // A finished row is loaded only if the output slot is free (or is being
  // freed this cycle) and the readback still has room for it. Rows past the
  // TB_SIZE limit vanish silently; only a lost in-budget row flags overrun.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    vec_d      = vec_q;
    valid_d    = valid_q;
    rowCount_d = rowCount_q;
    overrun_d  = overrun_q;

    if (start) begin
      state_d    = ACTIVE;
      lane_d     = '0;
      rowCount_d = '0;
      overrun_d  = 1'b0;
      valid_d    = 1'b0;
    end else if (state_q == ACTIVE) begin
      if (wordDone) begin
        asm_d[int'(lane_q) * DATA_WIDTH +: DATA_WIDTH] = word;
        lane_d = rowDone ? '0 : lane_q + 1'b1;
      end
      if (accept) begin
        rowCount_d = rowCount_q + 1'b1;
        valid_d    = 1'b0;
        if (rowCount_q == CW'(TB_SIZE - 1)) begin
          state_d = DONE;
        end
      end
      if (rowDone) begin
        if ((rowCount_d < CW'(TB_SIZE)) && (!valid_q || accept)) begin
          vec_d   = rowData;
          valid_d = 1'b1;
        end else if (valid_q && !accept && (rowCount_q < CW'(TB_SIZE - 1))) begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      asm_q      <= '0;
      vec_q      <= '0;
      valid_q    <= 1'b0;
      rowCount_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      vec_q      <= vec_d;
      valid_q    <= valid_d;
      rowCount_q <= rowCount_d;
      overrun_q  <= overrun_d;
    end
  end

  assign vector_out = vec_q;
  assign valid_out  = valid_q;
  assign row_count  = rowCount_q;
  assign done       = (state_q == DONE);
  assign overrun    = overrun_q;

endmodule

// File: doc/tb_readback_unpacker.md
TB_READBACK_UNPACKER -- requirements
Module: tb_readback_unpacker

Interface
REQ-001 SHALL have parameter N, default 8, meaning lanes per vector.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning bits per lane; a multiple of 8.
REQ-003 SHALL have parameter TB_SIZE, default 8, meaning number of trace-buffer rows per readback.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port rx_data, input, 8, meaning a received UART byte.
REQ-007 SHALL have port new_rx_data, input, 1, meaning a one-cycle strobe that rx_data is valid.
REQ-008 SHALL have port start, input, 1, meaning a one-cycle pulse that arms a new readback.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts vector_out this cycle.
REQ-010 SHALL have port vector_out, output, N x DATA_WIDTH, meaning the assembled trace-buffer row.
REQ-011 SHALL have port valid_out, output, 1, meaning vector_out holds an unaccepted row.
REQ-012 SHALL have port row_count, output, clog2(TB_SIZE+1), meaning rows accepted since start.
REQ-013 SHALL have port done, output, 1, meaning TB_SIZE rows have been accepted.
REQ-014 SHALL have port overrun, output, 1, meaning a sticky flag that a row was lost.

Function
REQ-015 SHALL implement states IDLE, ACTIVE, DONE; IDLE -> ACTIVE on start; ACTIVE -> DONE when the TB_SIZE-th row is accepted; DONE -> ACTIVE on start.
REQ-016 SHALL ignore new_rx_data in IDLE and DONE.
REQ-017 SHALL, in ACTIVE, pack bytes little-endian within a lane (first byte -> bits [7:0]), lane 0 filled first, lane N-1 last.
REQ-018 SHALL hold byte and lane indices that wrap to 0 after DATA_WIDTH/8 bytes and N lanes, respectively.
REQ-019 SHALL keep the assembly register separate from the output register, giving one row of buffering.
REQ-020 SHALL copy a completed row into vector_out and assert valid_out on the cycle after its last byte is sampled (latency 1).
REQ-021 SHALL keep vector_out and valid_out stable until a cycle with valid_out and out_ready both high; row_count then increments by 1.
REQ-022 SHALL continue collecting the next row while valid_out is held.
REQ-023 SHALL handle a row completing while valid_out is high and out_ready is low as follows: drop the new row, leave vector_out unchanged, set overrun.
REQ-024 SHALL handle a row completing in the same cycle as an accept as follows: load the new row with no overrun and keep valid_out high.
REQ-025 SHALL, in ACTIVE, accept no more than TB_SIZE rows; a completed row beyond that is dropped without setting overrun.
REQ-026 SHALL, on start in any state, clear byte/lane indices, row_count, overrun, done and valid_out, and enter ACTIVE; a byte strobed in the same cycle is dropped.
REQ-027 SHALL drive done high only in DONE; valid_out is low in DONE.

Reset
REQ-028 SHALL, while reset is low, immediately force IDLE, valid_out=0, done=0, overrun=0, row_count=0, vector_out=0 and indices=0, including mid-row.
REQ-029 SHALL, after reset deasserts, take no action until a start pulse.

Structure
REQ-030 SHALL place the state enum and the BYTES_PER_WORD constant in shared package tb_unpack_pkg.
REQ-031 SHALL use sub-module uart_word_packer (byte strobe in, DATA_WIDTH word plus word-complete strobe out); the top module owns lane index, output register, FSM and counters.

Verification
REQ-032 SHALL test: start, then 32 bytes 0x00..0x1F with out_ready=1 -> valid_out one cycle after byte 0x1F, lane0=0x03020100, lane7=0x1F1E1D1C, row_count=1.
REQ-033 SHALL test: 8 rows of 32 bytes each with out_ready=1 -> done=1, row_count=8; a further 32 bytes do not change vector_out.
REQ-034 SHALL test: out_ready=0 while 2 rows stream -> first row held unchanged, overrun=1, row_count=0; then out_ready=1 -> row_count=1.
REQ-035 SHALL test: out_ready asserted in the exact cycle the second row completes -> no overrun, second row presented, row_count=1.
REQ-036 SHALL test: reset pulsed low after 13 bytes, then start, then 32 bytes -> row packed from byte 0, no residue from the partial row.
REQ-037 SHALL test: start and new_rx_data coincident at byte 5 of a row -> indices cleared, that byte dropped, overrun=0.
